// File: rtl/requant_arbiter.sv
// Round-robin front end sharing one fixed-latency requantization datapath between two requesters,
// with a credit-reserved output FIFO. Optional per-requester ReLU clamp: define REQUANT_RELU_EN.
module requant_arbiter #(
    parameter int PIPE_LAT  = 3,
    parameter int OUT_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic signed [14:0] req0_val,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic signed [14:0] req1_val,
    output logic               req1_ready,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic signed [15:0] cfg_scale,
    input  logic        [3:0]  cfg_shift,
`ifdef REQUANT_RELU_EN
    input  logic               cfg_relu,
`endif
    output logic signed [14:0] dp_val,
    output logic signed [15:0] dp_scale,
    output logic        [3:0]  dp_shift,
    input  logic signed [15:0] dp_dout,
    output logic               out_valid,
    output logic               out_tag,
    output logic signed [15:0] out_data,
    input  logic               out_ready,
    output logic               busy
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(PIPE_LAT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic signed [15:0] r_scale [2];
    logic        [3:0]  r_shift [2];
    logic               r_rr_pri;
    logic signed [14:0] r_dp_val;
    logic signed [15:0] r_dp_scale;
    logic        [3:0]  r_dp_shift;
    logic [PIPE_LAT-1:0] r_dl_vld;
    logic [PIPE_LAT-1:0] r_dl_tag;
    logic [IW-1:0]      r_inflight;
    logic signed [15:0] r_mem     [OUT_DEPTH];
    logic               r_mem_tag [OUT_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic [SW-1:0]      w_occ;
    logic               w_credit;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_issue;
    logic               w_gid;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic signed [15:0] w_push_data;

    // Credit counts words already reserved: buffered plus still in the datapath.
    assign w_occ    = SW'(r_count) + SW'(r_inflight);
    assign w_credit = (w_occ < SW'(OUT_DEPTH));

    // r_rr_pri names the requester that wins the next tie, i.e. the one not served last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_credit) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = ~r_rr_pri;
                w_gnt1 = r_rr_pri;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_issue    = w_gnt0 | w_gnt1;
    assign w_gid      = w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scale[0] <= '0;
            r_scale[1] <= '0;
            r_shift[0] <= '0;
            r_shift[1] <= '0;
        end else if (cfg_we) begin
            r_scale[cfg_sel] <= cfg_scale;
            r_shift[cfg_sel] <= cfg_shift;
        end
    end

    // Issue stage: operand registers feed the external datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_val   <= '0;
            r_dp_scale <= '0;
            r_dp_shift <= '0;
            r_rr_pri   <= 1'b0;
        end else if (w_issue) begin
            r_dp_val   <= w_gid ? req1_val : req0_val;
            r_dp_scale <= r_scale[w_gid];
            r_dp_shift <= r_shift[w_gid];
            r_rr_pri   <= ~w_gid;
        end
    end

    assign dp_val   = r_dp_val;
    assign dp_scale = r_dp_scale;
    assign dp_shift = r_dp_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld <= '0;
            r_dl_tag <= '0;
        end else begin
            r_dl_vld[0] <= w_issue;
            r_dl_tag[0] <= w_gid;
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_dl_vld[k] <= r_dl_vld[k-1];
                r_dl_tag[k] <= r_dl_tag[k-1];
            end
        end
    end

`ifdef REQUANT_RELU_EN
    logic [1:0]          r_relu;
    logic [PIPE_LAT-1:0] r_dl_relu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_relu    <= '0;
            r_dl_relu <= '0;
        end else begin
            if (cfg_we) r_relu[cfg_sel] <= cfg_relu;
            r_dl_relu[0] <= w_issue & r_relu[w_gid];
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_dl_relu[k] <= r_dl_relu[k-1];
            end
        end
    end

    assign w_push_data = (r_dl_relu[PIPE_LAT-1] && dp_dout[15]) ? 16'sd0 : dp_dout;
`else
    assign w_push_data = dp_dout;
`endif

    // Return stage: tail of the delay line qualifies dp_dout into the FIFO.
    assign w_push = r_dl_vld[PIPE_LAT-1];
    assign w_pop  = out_valid & out_ready;
    assign w_full = (r_count == CW'(OUT_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr]     <= w_push_data;
            r_mem_tag[r_wptr] <= r_dl_tag[PIPE_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            assert (!w_full);
        end
    end
`endif

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rptr] : 16'sd0;
    assign out_tag   = out_valid ? r_mem_tag[r_rptr] : 1'b0;
    assign busy      = (r_inflight != '0) || (r_count != '0);

endmodule

// File: tb/tb_requant_arbiter.sv
// Directed bench for requant_arbiter; models the external 3-cycle datapath.
module tb_requant_arbiter;

    localparam int PIPE_LAT  = 3;
    localparam int OUT_DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req0_valid = 1'b0;
    logic signed [14:0] req0_val = '0;
    logic               req0_ready;
    logic               req1_valid = 1'b0;
    logic signed [14:0] req1_val = '0;
    logic               req1_ready;
    logic               cfg_we = 1'b0;
    logic               cfg_sel = 1'b0;
    logic signed [15:0] cfg_scale = '0;
    logic        [3:0]  cfg_shift = '0;
`ifdef REQUANT_RELU_EN
    logic               cfg_relu = 1'b0;
`endif
    logic signed [14:0] dp_val;
    logic signed [15:0] dp_scale;
    logic        [3:0]  dp_shift;
    logic signed [15:0] dp_dout;
    logic               out_valid;
    logic               out_tag;
    logic signed [15:0] out_data;
    logic               out_ready = 1'b0;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    requant_arbiter #(.PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_val(req0_val), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_val(req1_val), .req1_ready(req1_ready),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
`ifdef REQUANT_RELU_EN
        .cfg_relu(cfg_relu),
`endif
        .dp_val(dp_val), .dp_scale(dp_scale), .dp_shift(dp_shift), .dp_dout(dp_dout),
        .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External datapath: product/shift on the operand registers, then two more register stages.
    logic signed [30:0] dp_prod;
    logic signed [15:0] dp_d1, dp_d2;
    assign dp_prod = dp_val * dp_scale;
    always @(posedge clk) begin
        dp_d1 <= 16'(dp_prod >>> dp_shift);
        dp_d2 <= dp_d1;
    end
    assign dp_dout = dp_d2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [15:0] scale, input logic [3:0] shift);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_scale = scale;
        cfg_shift = shift;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic get_out(output bit ok, output logic tag, output logic [15:0] data);
        ok = 1'b0;
        tag = 1'b0;
        data = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                tag = out_tag;
                data = out_data;
            end
            step();
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if ({out_valid, busy, out_tag, req0_ready, req1_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=00000", {out_valid, busy, out_tag, req0_ready, req1_ready});
        end
        n_vec++;
        if (dp_val !== 15'd0 || dp_scale !== 16'd0 || dp_shift !== 4'd0 || out_data !== 16'd0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%h/%h/%h want=0", dp_val, dp_scale, dp_shift, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fairness;
        logic [15:0] exp_d [10] = '{16'd160, 16'd14, 16'd320, 16'd28, 16'd480,
                                    16'd42, 16'd640, 16'd56, 16'd800, 16'd70};
        logic [15:0] got_d [10];
        logic        got_t [10];
        int n0, n1, nout;
        logic g0, g1;
        cfg_write(1'b0, 16'h0100, 4'd4);
        cfg_write(1'b1, 16'h0002, 4'd0);
        n0 = 0; n1 = 0; nout = 0;
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_val = 15'sd10;
        req1_valid = 1'b1; req1_val = 15'sd7;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c < 10) begin
                n_vec++;
                if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_err++;
                    $display("FAIL fair_grant cycle=%0d ready=%b want=%b", c,
                             {req1_ready, req0_ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (out_valid && nout < 10) begin
                got_t[nout] = out_tag;
                got_d[nout] = out_data;
                nout++;
            end
            g0 = req0_ready;
            g1 = req1_ready;
            step();
            if (g0) begin n0++; req0_val = 15'(10 * (n0 + 1)); end
            if (g1) begin n1++; req1_val = 15'(7 * (n1 + 1)); end
            if (c == 9) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        n_vec++;
        if (nout != 10) begin
            n_err++;
            $display("FAIL fair_count outputs=%0d want=10", nout);
        end
        for (int i = 0; i < nout; i++) begin
            n_vec++;
            if (got_t[i] !== 1'(i % 2) || got_d[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL fair_out idx=%0d tag=%0d data=%0d want tag=%0d data=%0d",
                         i, got_t[i], got_d[i], i % 2, exp_d[i]);
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL fair_idle busy=%b want=0", busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_single;
        int lat;
        out_ready = 1'b0;
        req0_valid = 1'b1;
        req0_val = 15'sd100;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready got=%b want=1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dp_val !== 15'sd100 || dp_scale !== 16'h0100 || dp_shift !== 4'd4) begin
            n_err++;
            $display("FAIL single_dp got=%0d/%h/%0d want=100/0100/4", dp_val, dp_scale, dp_shift);
        end
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        n_vec++;
        if (lat != PIPE_LAT) begin
            n_err++;
            $display("FAIL single_latency got=%0d want=%0d", lat, PIPE_LAT);
        end
        n_vec++;
        if (out_tag !== 1'b0 || out_data !== 16'sd1600 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_out tag=%0d data=%0d busy=%b want 0/1600/1", out_tag, out_data, busy);
        end
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_pop valid=%b busy=%b want 0/0", out_valid, busy);
        end
        step();
    endtask

    task automatic test_back_to_back;
        int nacc, npop, nbad;
        out_ready = 1'b0;
        req0_valid = 1'b1;
        req0_val = 15'sd1;
        nacc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req0_ready) nacc++;
            step();
        end
        n_vec++;
        if (nacc != OUT_DEPTH) begin
            n_err++;
            $display("FAIL bp_accepts got=%0d want=%0d", nacc, OUT_DEPTH);
        end
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_full ready=%b valid=%b want 0/1", req0_ready, out_valid);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_pop_same_cycle ready=%b want=0", req0_ready);
        end
        step();
        out_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_credit_return ready=%b want=1", req0_ready);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_one_more ready=%b want=0", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        out_ready = 1'b1;
        npop = 0;
        nbad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                npop++;
                if (out_data !== 16'sd16 || out_tag !== 1'b0) nbad++;
            end
            step();
        end
        n_vec++;
        if (npop != OUT_DEPTH || nbad != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain pops=%0d bad=%0d busy=%b want %0d/0/0", npop, nbad, busy, OUT_DEPTH);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_config_race;
        bit ok;
        logic t;
        logic [15:0] d;
        out_ready = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_scale = 16'sd3; cfg_shift = 4'd0;
        req1_valid = 1'b1; req1_val = 15'sd10;
        @(negedge clk);
        n_vec++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL race_ready0 got=%b want=1", req1_ready);
        end
        step();
        cfg_we = 1'b0;
        req1_val = 15'sd20;
        @(negedge clk);
        n_vec++;
        if (dp_val !== 15'sd10 || dp_scale !== 16'sd2 || req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL race_old_scale dp=%0d/%0d ready=%b want 10/2/1", dp_val, dp_scale, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dp_val !== 15'sd20 || dp_scale !== 16'sd3) begin
            n_err++;
            $display("FAIL race_new_scale dp=%0d/%0d want 20/3", dp_val, dp_scale);
        end
        step();
        get_out(ok, t, d);
        n_vec++;
        if (!ok || t !== 1'b1 || d !== 16'd20) begin
            n_err++;
            $display("FAIL race_out0 ok=%0d tag=%0d data=%0d want 1/1/20", ok, t, d);
        end
        get_out(ok, t, d);
        n_vec++;
        if (!ok || t !== 1'b1 || d !== 16'd60) begin
            n_err++;
            $display("FAIL race_out1 ok=%0d tag=%0d data=%0d want 1/1/60", ok, t, d);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream;
        int stale;
        out_ready = 1'b0;
        req0_valid = 1'b1;
        req0_val = 15'sd5;
        for (int c = 0; c < 5; c++) step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_before valid=%b busy=%b want 1/1", out_valid, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dp_val !== 15'sd0) begin
            n_err++;
            $display("FAIL mid_async valid=%b busy=%b dp_val=%0d want 0/0/0", out_valid, busy, dp_val);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid || busy) stale++;
            step();
        end
        n_vec++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL mid_stale cycles=%0d want=0", stale);
        end
        out_ready = 1'b0;
    endtask

`ifdef REQUANT_RELU_EN
    task automatic test_relu;
        bit ok;
        logic t;
        logic [15:0] d;
        cfg_relu = 1'b1;
        cfg_write(1'b0, 16'hFFCE, 4'd0);
        cfg_relu = 1'b0;
        cfg_write(1'b1, 16'hFFCE, 4'd0);
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_val = 15'sd1;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_val = 15'sd1;
        step();
        req1_valid = 1'b0;
        get_out(ok, t, d);
        n_vec++;
        if (!ok || t !== 1'b0 || d !== 16'd0) begin
            n_err++;
            $display("FAIL relu_req0 ok=%0d tag=%0d data=%h want 1/0/0000", ok, t, d);
        end
        get_out(ok, t, d);
        n_vec++;
        if (!ok || t !== 1'b1 || d !== 16'hFFCE) begin
            n_err++;
            $display("FAIL relu_req1 ok=%0d tag=%0d data=%h want 1/1/ffce", ok, t, d);
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_back_to_back();
        test_config_race();
        test_reset_midstream();
`ifdef REQUANT_RELU_EN
        test_relu();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
